i2c_burst_writer: RTL

- Parametrised I2C write-only master for the segment-display bus; successor to the fixed single-frame display writer.
- Sends START, 7-bit address + W, then 0..MAX_BYTES data bytes from a valid/ready byte stream, checks ACK after every byte, then STOP.
- Drives the open-drain SDA split pins and SCL of the display controller; sits between the display sequencer and the board pads.

---
 rtl/i2c_burst_writer_if.sv | 18 +
 rtl/i2c_burst_writer.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/i2c_burst_writer_if.sv
// Byte stream between the display sequencer (master) and the burst writer (slave).
interface i2c_burst_writer_if;
  logic [7:0] data_i;
  logic       data_valid_i;
  logic       data_ready_o;

  modport master (
    output data_i,
    output data_valid_i,
    input  data_ready_o
  );

  modport slave (
    input  data_i,
    input  data_valid_i,
    output data_ready_o
  );
endinterface

// File: rtl/i2c_burst_writer.sv
// Write-only I2C master: START, address+W, 0..MAX_BYTES streamed data bytes with ACK checks, STOP.
module i2c_burst_writer #(
  parameter int unsigned QTR_DIV   = 25,
  parameter int unsigned MAX_BYTES = 16,
  parameter int unsigned LEN_W     = $clog2(MAX_BYTES + 1),
  parameter bit          ACK_CHECK = 1'b1
) (
  input  logic                 clk_i,
  input  logic                 porb_i,
  input  logic                 sync_reset_i,
  input  logic                 start_i,
  input  logic [6:0]           dev_addr_i,
  input  logic [LEN_W-1:0]     len_i,
  i2c_burst_writer_if.slave    stream,
  output logic                 busy_o,
  output logic                 done_o,
  output logic                 nack_o,
  output logic                 sda_out,
  input  logic                 sda_in,
  output logic                 sda_out_en,
  output logic                 seg_scl_o
);

  localparam int unsigned      CW      = (QTR_DIV > 1) ? $clog2(QTR_DIV) : 1;
  localparam logic [CW-1:0]    CntLast = CW'(QTR_DIV - 1);
  localparam logic [LEN_W-1:0] MaxLen  = LEN_W'(MAX_BYTES);

  typedef enum logic [2:0] {
    StIdle, StStart, StAddr, StAack, StFetch, StData, StDack, StStop
  } state_e;

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [1:0]       qtr_q, qtr_d;
  logic [2:0]       bit_q, bit_d;
  logic [7:0]       sr_q, sr_d;
  logic [LEN_W-1:0] left_q, left_d;
  logic             abort_q, abort_d;
  logic             done_q, done_d;
  logic             nack_q, nack_d;

  logic tick, bit_end, handshake;

  assign tick      = (cnt_q == CntLast);
  assign bit_end   = tick && (qtr_q == 2'd3);
  assign handshake = stream.data_ready_o && stream.data_valid_i;

  assign busy_o = (state_q != StIdle);
  assign done_o = done_q;
  assign nack_o = nack_q;

  // State and datapath registers; both resets return the bus to idle without a STOP.
  always_ff @(posedge clk_i or negedge porb_i) begin
    if (!porb_i) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      qtr_q   <= '0;
      bit_q   <= '0;
      sr_q    <= '0;
      left_q  <= '0;
      abort_q <= 1'b0;
      done_q  <= 1'b0;
      nack_q  <= 1'b0;
    end else if (sync_reset_i) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      qtr_q   <= '0;
      bit_q   <= '0;
      sr_q    <= '0;
      left_q  <= '0;
      abort_q <= 1'b0;
      done_q  <= 1'b0;
      nack_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      qtr_q   <= qtr_d;
      bit_q   <= bit_d;
      sr_q    <= sr_d;
      left_q  <= left_d;
      abort_q <= abort_d;
      done_q  <= done_d;
      nack_q  <= nack_d;
    end
  end

  // Next-state: quarter timing, bit sequencing, ACK evaluation and byte fetch.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    qtr_d   = qtr_q;
    bit_d   = bit_q;
    sr_d    = sr_q;
    left_d  = left_q;
    abort_d = abort_q;
    done_d  = 1'b0;
    nack_d  = nack_q;

    // Quarter timer runs whenever busy, except while waiting for a byte.
    if (state_q != StIdle && state_q != StFetch) begin
      cnt_d = tick ? '0 : cnt_q + 1'b1;
      if (tick) qtr_d = qtr_q + 2'd1;
    end

    unique case (state_q)
      StIdle: begin
        if (start_i) begin
          state_d = StStart;
          cnt_d   = '0;
          qtr_d   = '0;
          bit_d   = 3'd7;
          sr_d    = {dev_addr_i, 1'b0};
          left_d  = (len_i > MaxLen) ? MaxLen : len_i;
          abort_d = 1'b0;
          nack_d  = 1'b0;
        end
      end
      StStart: begin
        if (bit_end) state_d = StAddr;
      end
      StAddr, StData: begin
        if (bit_end) begin
          sr_d  = {sr_q[6:0], 1'b0};
          bit_d = bit_q - 3'd1;
          if (bit_q == 3'd0) state_d = (state_q == StAddr) ? StAack : StDack;
        end
      end
      StAack, StDack: begin
        if (tick && (qtr_q == 2'd2) && sda_in && ACK_CHECK) abort_d = 1'b1;
        if (bit_end) begin
          if (abort_q || (left_q == '0)) begin
            state_d = StStop;
          end else if (handshake) begin
            state_d = StData;
            sr_d    = stream.data_i;
            left_d  = left_q - 1'b1;
            bit_d   = 3'd7;
          end else begin
            state_d = StFetch;
          end
        end
      end
      StFetch: begin
        if (handshake) begin
          state_d = StData;
          sr_d    = stream.data_i;
          left_d  = left_q - 1'b1;
          bit_d   = 3'd7;
        end
      end
      StStop: begin
        if (bit_end) begin
          state_d = StIdle;
          done_d  = 1'b1;
          nack_d  = abort_q;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Pad and stream outputs decoded from state and quarter index.
  always_comb begin
    seg_scl_o           = 1'b1;
    sda_out             = 1'b1;
    sda_out_en          = 1'b0;
    stream.data_ready_o = 1'b0;
    unique case (state_q)
      StIdle: begin
      end
      StStart: begin
        sda_out_en = 1'b1;
        sda_out    = (qtr_q == 2'd0);
        seg_scl_o  = (qtr_q != 2'd3);
      end
      StAddr, StData: begin
        sda_out_en = 1'b1;
        sda_out    = sr_q[7];
        seg_scl_o  = qtr_q[1];
      end
      StAack, StDack: begin
        seg_scl_o = qtr_q[1];
        // Offer the fetch on the final cycle of the ACK bit so an available byte costs no time.
        stream.data_ready_o = bit_end && !abort_q && (left_q != '0);
      end
      StFetch: begin
        seg_scl_o           = 1'b0;
        stream.data_ready_o = 1'b1;
      end
      StStop: begin
        sda_out_en = (qtr_q != 2'd3);
        sda_out    = 1'b0;
        seg_scl_o  = qtr_q[1];
      end
      default: begin
      end
    endcase
  end

endmodule
